// File: rtl/cmd_proto_pkg.sv
// cmd_proto_pkg: definitions shared by the single-character command FSM and
// its host-side initiator (cmd_issuer).
//   - ASCII characters used on the Cmd / txData links
//   - result codes reported per transaction
//   - opcode classes and the initiator state encoding
//   - classifyResp(): maps a response byte to a result code for a given class
package cmd_proto_pkg;

  localparam logic [7:0] CH_ACK  = 8'h2A;  // '*'
  localparam logic [7:0] CH_ERR  = 8'h21;  // '!'
  localparam logic [7:0] CH_ZERO = 8'h30;  // '0'
  localparam logic [7:0] CH_ONE  = 8'h31;  // '1'
  localparam logic [7:0] CH_RU   = 8'h52;  // 'R'
  localparam logic [7:0] CH_RL   = 8'h72;  // 'r'
  localparam logic [7:0] CH_A    = 8'h41;  // 'A'
  localparam logic [7:0] CH_F    = 8'h46;  // 'F'
  localparam logic [7:0] CH_L    = 8'h4C;  // 'L'
  localparam logic [7:0] CH_V    = 8'h56;  // 'V'

  typedef enum logic [1:0] {
    RES_ACK     = 2'd0,
    RES_ERR     = 2'd1,
    RES_TIMEOUT = 2'd2,
    RES_BADRESP = 2'd3
  } result_t;

  typedef enum logic [1:0] {
    OPC_PLAIN   = 2'd0,  // expects '*' or '!'
    OPC_QUERY   = 2'd1,  // any reply byte is the answer
    OPC_NOREPLY = 2'd2   // responder sends nothing back
  } opClass_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_OP   = 3'd1,
    ST_GAP       = 3'd2,
    ST_SEND_BIT  = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_DONE      = 3'd5
  } cmdState_t;

  // Result for a classified byte that terminates a WAIT_RESP phase.
  function automatic result_t classifyResp(input opClass_t opClass, input logic [7:0] b);
    result_t r;
    if (opClass == OPC_QUERY) begin
      r = RES_ACK;
    end else if (b == CH_ACK) begin
      r = RES_ACK;
    end else if (b == CH_ERR) begin
      r = RES_ERR;
    end else begin
      r = RES_BADRESP;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmd_issuer_resp_classifier.sv
// cmd_issuer_resp_classifier (resp_classifier): opcode-class decode and the
// echo filter for the responder byte stream.
//   clk, rst_n  : clock, asynchronous active-low reset
//   opcode      : ASCII opcode, decoded combinationally into opClass
//   newCmd      : a character is being sent this cycle
//   echoEn      : responder echoes every character it receives
//   respValid   : responder byte strobe
//   opClass     : class of 'opcode'
//   accept      : respValid byte is a real response (not an echo)
module cmd_issuer_resp_classifier
  import cmd_proto_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opcode,
  input  logic       newCmd,
  input  logic       echoEn,
  input  logic       respValid,
  output opClass_t   opClass,
  output logic       accept
);

  logic [3:0] echoPend_r;
  logic [3:0] pendEff_s;
  logic [3:0] pendNext_s;

  // Opcode class decode.
  always_comb begin
    opClass = OPC_PLAIN;
    case (opcode)
      CH_A, CH_F, CH_L: opClass = OPC_QUERY;
      CH_RU, CH_RL:     opClass = OPC_NOREPLY;
      default:          opClass = OPC_PLAIN;
    endcase
  end

  // Echo bookkeeping: a character sent this cycle is counted before the
  // incoming byte is judged, so a simultaneous send and receive nets to zero
  // and that byte is treated as an echo.
  always_comb begin
    pendEff_s  = echoPend_r;
    pendNext_s = echoPend_r;
    accept     = 1'b0;
    if (newCmd && echoEn && (echoPend_r != 4'hF)) begin
      pendEff_s = echoPend_r + 4'd1;
    end else begin
      pendEff_s = echoPend_r;
    end
    if (respValid) begin
      if (pendEff_s != 4'd0) begin
        pendNext_s = pendEff_s - 4'd1;
        accept     = 1'b0;
      end else begin
        pendNext_s = pendEff_s;
        accept     = 1'b1;
      end
    end else begin
      pendNext_s = pendEff_s;
      accept     = 1'b0;
    end
  end

  // Outstanding-echo counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echoPend_r <= 4'd0;
    end else begin
      echoPend_r <= pendNext_s;
    end
  end

endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: host-side initiator for the single-character command protocol.
// Sends one opcode (optionally followed by a 10-bit payload as '0'/'1'
// characters, MSB first, CHAR_GAP clocks apart), then classifies the reply
// and reports one result per transaction.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : request, sampled only when idle
//   opcode, hasPayload,
//   payload, echoEn      : transaction description
//   respData, respValid  : responder txData / txDataWr
//   Cmd, NewCmd          : character to the responder and its strobe
//   busy, done           : in-progress flag, one-cycle completion pulse
//   result, respByte     : outcome and last classified byte, held until the next done
module cmd_issuer
  import cmd_proto_pkg::*;
#(
  parameter int CHAR_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic       hasPayload,
  input  logic [9:0] payload,
  input  logic       echoEn,
  input  logic [7:0] respData,
  input  logic       respValid,
  output logic [7:0] Cmd,
  output logic       NewCmd,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic [7:0] respByte
);

  // GAP lasts CHAR_GAP-1 cycles so consecutive NewCmd pulses are CHAR_GAP apart.
  localparam logic [TO_W-1:0] GAP_LAST = TO_W'(CHAR_GAP - 2);
  // Counter holds 0 on the first WAIT_RESP cycle; expiry moves to DONE so
  // that done lands exactly TIMEOUT_CYCLES cycles after WAIT_RESP entry.
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  cmdState_t       state_r;
  opClass_t        opClass_r;
  opClass_t        opClassDec_s;
  logic            hasPayload_r;
  logic [9:0]      payload_r;
  logic [3:0]      bitIdx_r;
  logic [TO_W-1:0] cnt_r;
  logic            accept_s;
  logic            errByte_s;

  cmd_issuer_resp_classifier u_classifier (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .newCmd    (NewCmd),
    .echoEn    (echoEn),
    .respValid (respValid),
    .opClass   (opClassDec_s),
    .accept    (accept_s)
  );

  // A real (non-echo) '!' aborts an in-flight payload.
  always_comb begin
    errByte_s = accept_s && (respData == CH_ERR);
  end

  // Transaction sequencer; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      opClass_r    <= OPC_PLAIN;
      hasPayload_r <= 1'b0;
      payload_r    <= 10'd0;
      bitIdx_r     <= 4'd0;
      cnt_r        <= '0;
      Cmd          <= 8'h00;
      NewCmd       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= 2'd0;
      respByte     <= 8'h00;
    end else begin
      NewCmd <= 1'b0;
      done   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_SEND_OP;
            opClass_r    <= opClassDec_s;
            hasPayload_r <= hasPayload;
            payload_r    <= payload;
            bitIdx_r     <= 4'd9;
            cnt_r        <= '0;
            Cmd          <= opcode;
            NewCmd       <= 1'b1;
            busy         <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SEND_OP: begin
          cnt_r <= '0;
          // No-reply opcodes reuse GAP as their fixed completion delay.
          if (hasPayload_r || (opClass_r == OPC_NOREPLY)) begin
            state_r <= ST_GAP;
          end else begin
            state_r <= ST_WAIT_RESP;
          end
        end
        ST_GAP: begin
          if (errByte_s) begin
            state_r  <= ST_DONE;
            result   <= RES_ERR;
            respByte <= CH_ERR;
            done     <= 1'b1;
          end else if (cnt_r == GAP_LAST) begin
            if (opClass_r == OPC_NOREPLY) begin
              state_r <= ST_DONE;
              result  <= RES_ACK;
              done    <= 1'b1;
            end else begin
              state_r <= ST_SEND_BIT;
              Cmd     <= payload_r[bitIdx_r] ? CH_ONE : CH_ZERO;
              NewCmd  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SEND_BIT: begin
          cnt_r <= '0;
          if (errByte_s) begin
            state_r  <= ST_DONE;
            result   <= RES_ERR;
            respByte <= CH_ERR;
            done     <= 1'b1;
          end else if (bitIdx_r == 4'd0) begin
            state_r <= ST_WAIT_RESP;
          end else begin
            bitIdx_r <= bitIdx_r - 4'd1;
            state_r  <= ST_GAP;
          end
        end
        ST_WAIT_RESP: begin
          // A response in the expiry cycle takes precedence over the timeout.
          if (accept_s) begin
            state_r  <= ST_DONE;
            result   <= classifyResp(opClass_r, respData);
            respByte <= respData;
            done     <= 1'b1;
          end else if (cnt_r == TO_LAST) begin
            state_r <= ST_DONE;
            result  <= RES_TIMEOUT;
            done    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cmd_issuer.md
Name: cmd_issuer

Overview:
- Host-side initiator for the single-character command protocol: drives Cmd/NewCmd into the command FSM and consumes its txData/txDataWr response stream.
- Issues one opcode, optionally followed by a 10-bit trigger-voltage payload as ASCII '0'/'1' characters.
- Classifies the reply as ack ('*'), error ('!'), query digit or timeout, and reports one result per transaction.
- Sits between an on-chip sequencer or self-test controller and the command FSM, in place of the UART receiver path.

Parameters:
- CHAR_GAP, 4: clocks from one NewCmd pulse to the next (≥3, so the responder can return to its payload-receive state).
- TIMEOUT_CYCLES, 1024: clocks to wait for a response after the last character is sent.
- TO_W, 16: timeout counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- opcode  in  8  ASCII command character
- hasPayload  in  1  send the 10-bit payload after the opcode (the 'V' command)
- payload  in  10  trigger-voltage bits, sent MSB first
- echoEn  in  1  responder echo is on; discard echoed characters
- respData  in  8  responder txData
- respValid  in  1  responder txDataWr
- Cmd  out  8  command character to responder
- NewCmd  out  1  one-cycle strobe qualifying Cmd
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- result  out  2  0 ACK, 1 ERR, 2 TIMEOUT, 3 BADRESP; valid with done, held until next done
- respByte  out  8  last classified response byte; held

Behaviour:
- Reset: state IDLE; Cmd=0, NewCmd=0, busy=0, done=0, result=0, respByte=0; all counters 0. Reset mid-transaction abandons it; no done is issued.
- States:
  - IDLE -> SEND_OP on start. Opcode class is decoded and registered at this point.
  - SEND_OP: Cmd=opcode, NewCmd=1 for 1 cycle. Then -> GAP if hasPayload, else -> WAIT_RESP.
  - GAP: counts CHAR_GAP-1 cycles -> SEND_BIT.
  - SEND_BIT: Cmd="0"/"1" from payload[bitIdx], NewCmd=1, bitIdx decrements from 9. Returns to GAP; after bit 0 goes -> WAIT_RESP.
  - WAIT_RESP: waits for a classified byte or timeout -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- busy=1 in every state except IDLE. start while busy is ignored.
- Opcode classes:
  - Query 'A','F','L': any classified byte is ACK and is captured in respByte.
  - No-reply 'R','r': skip WAIT_RESP. Go to DONE with ACK after CHAR_GAP cycles.
  - All others: '*' gives ACK, '!' gives ERR, any other byte gives BADRESP.
- Echo filter:
  - echoPend (4 bits) increments on each NewCmd when echoEn=1 and decrements on each respValid while nonzero. Increment and decrement in the same cycle leave it unchanged.
  - A respValid arriving while echoPend>0 (after the same-cycle update rule) is discarded. Only other bytes are classified.
- '!' received during GAP or SEND_BIT aborts the remaining payload: result ERR -> DONE, respByte="!". Any other classified byte in those states is ignored.
- Timeout:
  - Counter clears on WAIT_RESP entry and counts each cycle.
  - Reaching TIMEOUT_CYCLES gives TIMEOUT, respByte unchanged.
  - respValid and expiry in the same cycle: the response wins.
- respValid in IDLE or DONE is ignored.
- Latency, non-payload opcode: NewCmd 1 cycle after start. done 1 cycle after the classified byte.
- Payload transaction: exactly 11 NewCmd pulses spaced CHAR_GAP apart.

Decomposition:
- Shared package cmd_proto_pkg:
  - ASCII constants for ACK '*', ERR '!', '0', '1', 'R', 'r', 'A', 'F', 'L', 'V'.
  - Result codes.
  - State encoding.
- The same package is used by the command FSM and this block.
- One natural sub-module, resp_classifier: combinational opcode-class decode plus the echo filter counter and its discard logic.

Test Plan:
- opcode="E", no echo; responder returns '*' 3 cycles after NewCmd -> one NewCmd with Cmd=0x45; done 1 cycle later with result=0, respByte=0x2A.
- opcode="V", payload=10'b1010011100, CHAR_GAP=4 -> 11 NewCmd pulses 4 cycles apart carrying "V1010011100"; responder '*' -> result ACK.
- opcode="A"; responder returns '3' -> result ACK, respByte=0x33; returning '*' for "A" is also ACK.
- opcode="T", TIMEOUT_CYCLES=16, no reply -> done exactly 16 cycles after WAIT_RESP entry with result=2. Repeat with respValid on cycle 16 -> result ACK.
- "V" payload, responder sends '!' after the 4th bit -> no further NewCmd, result=1. echoEn=1 with each character echoed the next cycle -> echoes discarded, final '*' gives ACK.
- rst_n asserted low mid-payload -> NewCmd=0 and busy=0 immediately. No done; the next start proceeds normally.
